// File: rtl/level_updncnt_pkg.sv
// Shared types and mode constants for the up/down level counter.
package level_updncnt_pkg;

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
   typedef enum logic {DIR_UP, DIR_DN} dir_t;

   localparam int unsigned WRAP_SAT = 0;
   localparam int unsigned WRAP_ON  = 1;

endpackage

// File: rtl/rpt_timer.sv
// Press-and-hold timer: counts cycles since the last step and flags when the
// current phase (first-repeat delay or repeat period) has elapsed.
module rpt_timer #(
   parameter int unsigned HOLD_CYC   = 500,
   parameter int unsigned REPEAT_CYC = 100
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic start,
   input  logic sel,
   output logic expire
);

   localparam int unsigned TOP = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
   localparam int unsigned TW  = $clog2(TOP + 1);
   localparam logic [TW-1:0] HOLD_T = TW'(HOLD_CYC);
   localparam logic [TW-1:0] RPT_T  = TW'(REPEAT_CYC);

   logic [TW-1:0] timer;

   // start loads 1 because the step that restarts the phase is cycle 0
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         timer <= '0;
      end else if (start) begin
         timer <= TW'(1);
      end else begin
         timer <= timer + TW'(1);
      end
   end

   assign expire = (timer == (sel ? RPT_T : HOLD_T));

endmodule

// File: rtl/level_updncnt.sv
// Up/down level counter with saturate/wrap bounds, clamped load and
// press-and-hold auto-repeat; drives the PWM duty-cycle level.
module level_updncnt
   import level_updncnt_pkg::*;
#(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned STEP       = 1,
   parameter int unsigned MIN        = 0,
   parameter int unsigned MAX        = (2 ** WIDTH) - 1,
   parameter int unsigned RST_VAL    = MIN,
   parameter int unsigned WRAP       = WRAP_SAT,
   parameter int unsigned HOLD_CYC   = 500,
   parameter int unsigned REPEAT_CYC = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             dec,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             at_max,
   output logic             at_min,
   output logic             step_pulse
);

   localparam int unsigned EW = WIDTH + 1;
   localparam int unsigned SW = WIDTH + 2;
   localparam logic [EW-1:0]    STEP_X = EW'(STEP);
   localparam logic [EW-1:0]    MIN_X  = EW'(MIN);
   localparam logic [EW-1:0]    MAX_X  = EW'(MAX);
   localparam logic [SW-1:0]    MIN_S  = SW'(MIN);
   localparam logic [SW-1:0]    MAX_S  = SW'(MAX);
   localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RST_VAL);

   state_t           state, state_n;
   dir_t             dir, dir_n, req_dir;
   logic             req, do_step, t_clear, t_start, expire;
   logic [EW-1:0]    up_sum, dn_diff;
   logic [SW-1:0]    lv_s;
   logic [WIDTH-1:0] step_val, load_clamp, cnt_n;
   logic             pulse_n;

   rpt_timer #(
      .HOLD_CYC   (HOLD_CYC),
      .REPEAT_CYC (REPEAT_CYC)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (t_clear),
      .start  (t_start),
      .sel    (state == REPEAT),
      .expire (expire)
   );

   // Press/hold/repeat sequencing; a new press or direction flip steps at once
   always_comb begin
      state_n = state;
      dir_n   = dir;
      do_step = 1'b0;
      t_clear = 1'b0;
      t_start = 1'b0;
      req     = inc | dec;
      req_dir = inc ? DIR_UP : DIR_DN;
      if (load) begin
         state_n = IDLE;
         t_clear = 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  do_step = 1'b1;
                  dir_n   = req_dir;
                  state_n = HOLD;
                  t_start = 1'b1;
               end else begin
                  t_clear = 1'b1;
               end
            end
            HOLD, REPEAT: begin
               if (!req) begin
                  state_n = IDLE;
                  t_clear = 1'b1;
               end else if (req_dir != dir) begin
                  do_step = 1'b1;
                  dir_n   = req_dir;
                  state_n = HOLD;
                  t_start = 1'b1;
               end else if (expire) begin
                  do_step = 1'b1;
                  state_n = REPEAT;
                  t_start = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               t_clear = 1'b1;
            end
         endcase
      end
   end

   // One extra bit keeps cnt+STEP and the signed cnt-STEP free of overflow
   always_comb begin
      up_sum  = {1'b0, cnt} + STEP_X;
      dn_diff = {1'b0, cnt} - STEP_X;
      if (dir_n == DIR_UP) begin
         if (up_sum > MAX_X) step_val = (WRAP == WRAP_ON) ? MIN_W : MAX_W;
         else                step_val = up_sum[WIDTH-1:0];
      end else begin
         if ($signed(dn_diff) < $signed(MIN_X)) step_val = (WRAP == WRAP_ON) ? MAX_W : MIN_W;
         else                                   step_val = dn_diff[WIDTH-1:0];
      end

      lv_s = {2'b00, load_val};
      if ($signed(lv_s) < $signed(MIN_S))      load_clamp = MIN_W;
      else if ($signed(lv_s) > $signed(MAX_S)) load_clamp = MAX_W;
      else                                     load_clamp = load_val;

      if (load)         cnt_n = load_clamp;
      else if (do_step) cnt_n = step_val;
      else              cnt_n = cnt;
      pulse_n = do_step && (step_val != cnt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         dir        <= DIR_UP;
         cnt        <= RST_W;
         step_pulse <= 1'b0;
         at_max     <= (RST_W == MAX_W);
         at_min     <= (RST_W == MIN_W);
      end else begin
         state      <= state_n;
         dir        <= dir_n;
         cnt        <= cnt_n;
         step_pulse <= pulse_n;
         at_max     <= (cnt_n == MAX_W);
         at_min     <= (cnt_n == MIN_W);
      end
   end

endmodule

// File: tb/tb_level_updncnt.sv
// Bench for level_updncnt: five parameterisations share one stimulus stream,
// a reference model fills a scoreboard queue and a monitor checks every cycle.
module tb_level_updncnt;

   localparam int N = 5;

   typedef struct {
      int w; int step; int mn; int mx; int rst; int wrap; int hold; int rep;
   } cfg_t;

   typedef struct {
      int cnt; bit active; bit up; int age;
   } mdl_t;

   typedef struct packed {
      logic [7:0] cnt;
      logic       amax;
      logic       amin;
      logic       pls;
   } exp_t;

   typedef exp_t [N-1:0] row_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inc = 1'b0;
   logic       dec = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;

   logic [7:0] cnt_v [N-1];
   logic [3:0] cnt_e;
   logic       amax [N];
   logic       amin [N];
   logic       pls  [N];

   cfg_t cfg [N];
   mdl_t mdl [N];
   row_t sb_q [$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always #5 clk = ~clk;

   level_updncnt #(.WIDTH(8), .STEP(1), .MIN(0), .MAX(255), .RST_VAL(0), .WRAP(0),
                   .HOLD_CYC(5), .REPEAT_CYC(3)) u_a (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
      .cnt(cnt_v[0]), .at_max(amax[0]), .at_min(amin[0]), .step_pulse(pls[0]));

   level_updncnt #(.WIDTH(8), .STEP(16), .MIN(0), .MAX(200), .RST_VAL(0), .WRAP(0),
                   .HOLD_CYC(4), .REPEAT_CYC(2)) u_b (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
      .cnt(cnt_v[1]), .at_max(amax[1]), .at_min(amin[1]), .step_pulse(pls[1]));

   level_updncnt #(.WIDTH(8), .STEP(16), .MIN(0), .MAX(200), .RST_VAL(100), .WRAP(1),
                   .HOLD_CYC(4), .REPEAT_CYC(2)) u_c (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
      .cnt(cnt_v[2]), .at_max(amax[2]), .at_min(amin[2]), .step_pulse(pls[2]));

   level_updncnt #(.WIDTH(8), .STEP(3), .MIN(10), .MAX(100), .RST_VAL(50), .WRAP(1),
                   .HOLD_CYC(3), .REPEAT_CYC(1)) u_d (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_val(load_val),
      .cnt(cnt_v[3]), .at_max(amax[3]), .at_min(amin[3]), .step_pulse(pls[3]));

   level_updncnt #(.WIDTH(4), .STEP(5), .MIN(2), .MAX(15), .RST_VAL(7), .WRAP(1),
                   .HOLD_CYC(2), .REPEAT_CYC(2)) u_e (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec), .load(load), .load_val(load_val[3:0]),
      .cnt(cnt_e), .at_max(amax[4]), .at_min(amin[4]), .step_pulse(pls[4]));

   // Bounded step in plain integer arithmetic
   function automatic int next_level(cfg_t c, int v, bit up);
      int r;
      if (up) begin
         r = v + c.step;
         if (r > c.mx) r = c.wrap ? c.mn : c.mx;
      end else begin
         r = v - c.step;
         if (r < c.mn) r = c.wrap ? c.mx : c.mn;
      end
      return r;
   endfunction

   // Drive one cycle of inputs and push the model's post-edge outputs
   task automatic drive(bit r_n, bit i, bit d, bit l, logic [7:0] lv);
      row_t row;
      @(negedge clk);
      rst_n = r_n; inc = i; dec = d; load = l; load_val = lv;
      for (int k = 0; k < N; k++) begin
         int   old;
         int   lvk;
         bit   p;
         bit   up;
         exp_t e;
         old = mdl[k].cnt;
         lvk = int'(lv) % (1 << cfg[k].w);
         p   = 1'b0;
         up  = i;
         if (!r_n) begin
            mdl[k].cnt = cfg[k].rst;
            mdl[k].active = 1'b0;
         end else if (l) begin
            mdl[k].cnt = (lvk < cfg[k].mn) ? cfg[k].mn : (lvk > cfg[k].mx) ? cfg[k].mx : lvk;
            mdl[k].active = 1'b0;
         end else if (!(i || d)) begin
            mdl[k].active = 1'b0;
         end else begin
            if (!mdl[k].active || up != mdl[k].up) begin
               mdl[k].active = 1'b1;
               mdl[k].up     = up;
               mdl[k].age    = 0;
               mdl[k].cnt    = next_level(cfg[k], mdl[k].cnt, up);
            end else begin
               mdl[k].age++;
               if (mdl[k].age == cfg[k].hold ||
                   (mdl[k].age > cfg[k].hold && (mdl[k].age - cfg[k].hold) % cfg[k].rep == 0))
                  mdl[k].cnt = next_level(cfg[k], mdl[k].cnt, up);
            end
            p = (mdl[k].cnt != old);
         end
         e.cnt  = 8'(mdl[k].cnt);
         e.amax = (mdl[k].cnt == cfg[k].mx);
         e.amin = (mdl[k].cnt == cfg[k].mn);
         e.pls  = p;
         row[k] = e;
      end
      sb_q.push_back(row);
   endtask

   task automatic idle(int n);
      repeat (n) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
   endtask

   task automatic hold_req(int n, bit i, bit d);
      repeat (n) drive(1'b1, i, d, 1'b0, 8'd0);
   endtask

   // Monitor: one scoreboard row per clock, sampled just after the edge
   initial begin
      row_t exp_row;
      exp_t act;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sb_q.size() > 0) begin
            exp_row = sb_q.pop_front();
            for (int k = 0; k < N; k++) begin
               if (k == N - 1) act.cnt = 8'(cnt_e);
               else            act.cnt = cnt_v[k];
               act.amax = amax[k];
               act.amin = amin[k];
               act.pls  = pls[k];
               total++;
               if (act !== exp_row[k]) begin
                  bad++;
                  $display("FAIL dut%0d cycle %0d: cnt/max/min/pulse got %0d/%b/%b/%b want %0d/%b/%b/%b",
                           k, cyc, act.cnt, act.amax, act.amin, act.pls,
                           exp_row[k].cnt, exp_row[k].amax, exp_row[k].amin, exp_row[k].pls);
               end
            end
         end
      end
   end

   initial begin
      cfg[0] = '{8, 1,  0,  255, 0,   0, 5, 3};
      cfg[1] = '{8, 16, 0,  200, 0,   0, 4, 2};
      cfg[2] = '{8, 16, 0,  200, 100, 1, 4, 2};
      cfg[3] = '{8, 3,  10, 100, 50,  1, 3, 1};
      cfg[4] = '{4, 5,  2,  15,  7,   1, 2, 2};
      for (int k = 0; k < N; k++) mdl[k] = '{0, 1'b0, 1'b0, 0};

      // reset, then quiet
      repeat (2) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      idle(3);
      // single presses and inc-over-dec priority
      hold_req(1, 1'b1, 1'b0); idle(2);
      hold_req(1, 1'b1, 1'b1); idle(2);
      // auto-repeat ramp from 10
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd10);
      hold_req(12, 1'b1, 1'b0); idle(3);
      // saturate/wrap near the top
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd190);
      hold_req(1, 1'b1, 1'b0); idle(1);
      hold_req(1, 1'b1, 1'b0); idle(1);
      hold_req(6, 1'b1, 1'b0); idle(1);
      // wrap below the bottom
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd5);
      hold_req(1, 1'b0, 1'b1); idle(1);
      // load clamp both ways
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd250); idle(1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'd3);   idle(1);
      // load mid-repeat with inc still held
      hold_req(10, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'd50);
      hold_req(8, 1'b1, 1'b0); idle(1);
      // direction change mid-repeat
      hold_req(12, 1'b1, 1'b0);
      hold_req(10, 1'b0, 1'b1); idle(1);
      // reset mid-ramp
      hold_req(10, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      hold_req(3, 1'b1, 1'b0); idle(2);

      // random bursts of held requests with occasional load / reset
      for (int s = 0; s < 250; s++) begin
         int m;
         int len;
         bit i;
         bit d;
         m   = $urandom_range(0, 9);
         len = $urandom_range(1, 14);
         i   = (m <= 3) || (m == 7);
         d   = (m >= 4) && (m <= 7);
         for (int c = 0; c < len; c++) begin
            bit r_n;
            bit l;
            r_n = ($urandom_range(0, 149) != 0);
            l   = ($urandom_range(0, 24) == 0);
            drive(r_n, i, d, l, 8'($urandom_range(0, 255)));
         end
      end
      idle(2);

      // let the monitor drain, bounded
      for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(posedge clk);
      #2;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d rows left, want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
